dmem_lsu: RTL and testbench

//  Load/store unit that initiates accesses on the word-wide data-memory port and serves core loads/stores.

---
 rtl/dmem_lsu.sv | 228 ++++++++++++++++++++++
 tb/tb_dmem_lsu.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
//   Load/store unit between the core execute stage and a word-wide, registered-
//   read data memory. Adds byte/half/word sizes, sign/zero extension, alignment
//   and bounds checking. Sub-word stores are done as read-modify-write.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   core request handshake (ready only while idle)
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      load zero-extend (1) / sign-extend (0)
//   req_addr          byte address
//   req_wdata         right-justified store data
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data (0 for stores and errors)
//   resp_err          misaligned / out of bounds / illegal size
//   mem_write_en      one-cycle memory write strobe
//   mem_addr          word-aligned memory address
//   mem_write_data    full word written to memory
//   mem_read_data     memory read data, valid the cycle after mem_addr
// -----------------------------------------------------------------------------
module dmem_lsu #(
   parameter int unsigned MEM_BYTES = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_write_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_ISSUE = 3'd1,
      S_RD_WAIT  = 3'd2,
      S_WR_ISSUE = 3'd3,
      S_ERR      = 3'd4,
      S_RESP     = 3'd5
   } state_t;

   // Pick the addressed lane out of a memory word and extend it to 32 bits.
   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic        uns);
      logic [31:0] shifted;
      logic [31:0] result;
      shifted = 32'h0000_0000;
      result  = word;
      case (size)
         2'b00: begin
            shifted = word >> {off, 3'b000};
            result  = uns ? {24'h00_0000, shifted[7:0]}
                          : {{24{shifted[7]}}, shifted[7:0]};
         end
         2'b01: begin
            shifted = word >> {off[1], 4'b0000};
            result  = uns ? {16'h0000, shifted[15:0]}
                          : {{16{shifted[15]}}, shifted[15:0]};
         end
         default: result = word;
      endcase
      return result;
   endfunction

   // Replace only the addressed lane of a memory word with the store data.
   function automatic logic [31:0] store_merge(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic [15:0] wdata);
      logic [31:0] mask;
      logic [31:0] data;
      case (size)
         2'b00: begin
            mask = 32'h0000_00FF << {off, 3'b000};
            data = {24'h00_0000, wdata[7:0]} << {off, 3'b000};
         end
         2'b01: begin
            mask = 32'h0000_FFFF << {off[1], 4'b0000};
            data = {16'h0000, wdata} << {off[1], 4'b0000};
         end
         default: begin
            mask = 32'h0000_0000;
            data = 32'h0000_0000;
         end
      endcase
      return (word & ~mask) | (data & mask);
   endfunction

   state_t      state_q, state_d;
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        mem_write_en_q, mem_write_en_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_write_data_q, mem_write_data_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [1:0]  off_q, off_d;
   logic [15:0] wdata_q, wdata_d;
   logic        req_err_s;

   // Request legality: illegal size, misalignment, or word beyond the last one.
   always_comb begin
      req_err_s = (req_size == 2'b11)
                | ((req_size == 2'b01) & req_addr[0])
                | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                | ({req_addr[31:2], 2'b00} > LAST_WORD);
   end

   // Next-state and next-output logic; every output is registered.
   always_comb begin
      state_d          = state_q;
      resp_valid_d     = 1'b0;
      resp_err_d       = 1'b0;
      resp_rdata_d     = 32'h0000_0000;
      mem_addr_d       = mem_addr_q;
      mem_write_data_d = mem_write_data_q;
      we_d             = we_q;
      size_d           = size_q;
      uns_d            = uns_q;
      off_d            = off_q;
      wdata_d          = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               we_d    = req_we;
               size_d  = req_size;
               uns_d   = req_unsigned;
               off_d   = req_addr[1:0];
               wdata_d = req_wdata[15:0];
               if (req_err_s) begin
                  state_d      = S_ERR;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (!req_we || (req_size != 2'b10)) begin
                  state_d    = S_RD_ISSUE;
                  mem_addr_d = {req_addr[31:2], 2'b00};
               end else begin
                  state_d          = S_WR_ISSUE;
                  mem_addr_d       = {req_addr[31:2], 2'b00};
                  mem_write_data_d = req_wdata;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RD_ISSUE: state_d = S_RD_WAIT;
         S_RD_WAIT: begin
            if (!we_q) begin
               resp_rdata_d = load_extract(mem_read_data, size_q, off_q, uns_q);
               resp_valid_d = 1'b1;
               state_d      = S_RESP;
            end else begin
               mem_write_data_d = store_merge(mem_read_data, size_q, off_q, wdata_q);
               state_d          = S_WR_ISSUE;
            end
         end
         S_WR_ISSUE: begin
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
         end
         S_ERR:   state_d = S_IDLE;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      mem_write_en_d = (state_d == S_WR_ISSUE);
      req_ready_d    = (state_d == S_IDLE);
   end

   // State and output registers; reset drops any in-flight write immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= S_IDLE;
         req_ready_q      <= 1'b1;
         resp_valid_q     <= 1'b0;
         resp_err_q       <= 1'b0;
         resp_rdata_q     <= 32'h0000_0000;
         mem_write_en_q   <= 1'b0;
         mem_addr_q       <= 32'h0000_0000;
         mem_write_data_q <= 32'h0000_0000;
         we_q             <= 1'b0;
         size_q           <= 2'b00;
         uns_q            <= 1'b0;
         off_q            <= 2'b00;
         wdata_q          <= 16'h0000;
      end else begin
         state_q          <= state_d;
         req_ready_q      <= req_ready_d;
         resp_valid_q     <= resp_valid_d;
         resp_err_q       <= resp_err_d;
         resp_rdata_q     <= resp_rdata_d;
         mem_write_en_q   <= mem_write_en_d;
         mem_addr_q       <= mem_addr_d;
         mem_write_data_q <= mem_write_data_d;
         we_q             <= we_d;
         size_q           <= size_d;
         uns_q            <= uns_d;
         off_q            <= off_d;
         wdata_q          <= wdata_d;
      end
   end

   assign req_ready      = req_ready_q;
   assign resp_valid     = resp_valid_q;
   assign resp_err       = resp_err_q;
   assign resp_rdata     = resp_rdata_q;
   assign mem_write_en   = mem_write_en_q;
   assign mem_addr       = mem_addr_q;
   assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu
//   Scoreboard bench for dmem_lsu with a registered-read memory model.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;

   localparam int unsigned MEM_BYTES = 4096;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_write_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data = 32'h0;

   dmem_lsu #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] mem [0:1023];
   int          pcyc = 0;
   int          wr_cnt = 0;
   logic [31:0] last_wa = 32'h0;
   logic [31:0] last_wd = 32'h0;
   int          n_tests = 0;
   int          n_fail = 0;
   int          acc_cyc = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory model: registered read, write on strobe; also records writes.
   always @(posedge clk) begin
      pcyc <= pcyc + 1;
      mem_read_data <= mem[mem_addr[11:2]];
      if (mem_write_en) begin
         mem[mem_addr[11:2]] <= mem_write_data;
         wr_cnt  <= wr_cnt + 1;
         last_wa <= mem_addr;
         last_wd <= mem_write_data;
      end
   end

   // Response monitor: pop the scoreboard on each resp_valid.
   always @(negedge clk) begin
      if (rst_n && resp_valid) begin
         if (sb_q.size() == 0) begin
            check_eq("unexpected_resp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq("rdata", resp_rdata, e.rdata);
            check_eq("err", {31'd0, resp_err}, {31'd0, e.err});
            check_eq("latency", 32'(pcyc - e.acc), 32'(e.lat));
         end
      end
   end

   // Drive one request; returns 1 time unit after the accept edge.
   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      int n;
      @(posedge clk); #1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) check_eq("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b1; req_we = we; req_size = size;
      req_unsigned = uns; req_addr = addr; req_wdata = wdata;
      acc_cyc = pcyc;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_we = $urandom_range(0, 1) != 0;
      req_addr = $urandom; req_wdata = $urandom;
   endtask

   // Full transaction: push expectation, drive, wait for the response.
   task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err, input int lat);
      exp_t e;
      int n;
      e.rdata = exp_rd; e.err = exp_err; e.lat = lat;
      issue(we, size, uns, addr, wdata);
      e.acc = acc_cyc;
      sb_q.push_back(e);
      n = 0;
      while (sb_q.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         check_eq("resp_timeout", 32'd0, 32'd1);
         sb_q.delete();
      end
   endtask

   initial begin
      int w0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[32'h10 >> 2]  = 32'hDEADBEEF;
      mem[32'h20 >> 2]  = 32'hCAFEF00D;
      mem[1023]         = 32'hFFFFFFFF;

      #12;
      check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
      check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check_eq("rst_mem_we", {31'd0, mem_write_en}, 32'd0);
      check_eq("rst_mem_addr", mem_addr, 32'h0);
      check_eq("rst_mem_wdata", mem_write_data, 32'h0);
      @(negedge clk); rst_n = 1'b1;

      // Loads from the preloaded word, no writes expected.
      w0 = wr_cnt;
      txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);
      txn(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 3);
      txn(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0, 3);
      txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 3);
      txn(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 3);
      txn(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 32'hFFFFFFFF, 1'b0, 3);
      check_eq("load_no_write", 32'(wr_cnt - w0), 32'd0);

      // Byte store via read-modify-write.
      w0 = wr_cnt;
      txn(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055, 32'h0, 1'b0, 4);
      check_eq("sb_wr_count", 32'(wr_cnt - w0), 32'd1);
      check_eq("sb_wr_addr", last_wa, 32'h10);
      check_eq("sb_wr_data", last_wd, 32'hDEAD55EF);
      txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 3);

      // Word store, then half store merged into it.
      txn(1'b1, 2'b10, 1'b0, 32'h14, 32'h12345678, 32'h0, 1'b0, 2);
      txn(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h12345678, 1'b0, 3);
      txn(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000AAAA, 32'h0, 1'b0, 4);
      txn(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'hAAAA5678, 1'b0, 3);

      // Error requests: no memory access.
      w0 = wr_cnt;
      txn(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1);
      txn(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1);
      txn(1'b0, 2'b10, 1'b0, MEM_BYTES, 32'h0, 32'h0, 1'b1, 1);
      txn(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1);
      txn(1'b1, 2'b00, 1'b0, MEM_BYTES + 1, 32'h77, 32'h0, 1'b1, 1);
      check_eq("err_no_write", 32'(wr_cnt - w0), 32'd0);

      // Random byte store / load pairs.
      for (int i = 0; i < 6; i++) begin
         logic [31:0] a;
         logic [7:0]  d;
         a = 32'h100 + 32'($urandom_range(0, 255));
         d = 8'($urandom);
         txn(1'b1, 2'b00, 1'b0, a, {24'($urandom), d}, 32'h0, 1'b0, 4);
         txn(1'b0, 2'b00, 1'b1, a, 32'h0, {24'h0, d}, 1'b0, 3);
         txn(1'b0, 2'b00, 1'b0, a, 32'h0, {{24{d[7]}}, d}, 1'b0, 3);
      end

      // Reset during the write cycle of a word store.
      w0 = wr_cnt;
      issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h11111111);
      check_eq("wr_issue_we", {31'd0, mem_write_en}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("rst_drops_we", {31'd0, mem_write_en}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("post_rst_ready", {31'd0, req_ready}, 32'd1);
      check_eq("post_rst_word", mem[32'h20 >> 2], 32'hCAFEF00D);
      check_eq("post_rst_no_write", 32'(wr_cnt - w0), 32'd0);
      repeat (4) @(posedge clk);
      txn(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
